// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and helpers for the register slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_STRB_WIDTH = 4;

  function automatic logic in_range(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/axi_lite_reg_cell.sv
// One 32-bit control register with byte-enable write and a write pulse
// that coincides with the first cycle the new value is visible.
module axi_lite_reg_cell
  import axi_lite_pkg::*;
#(
  parameter logic [AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AXI_STRB_WIDTH-1:0] strb,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic [AXI_DATA_WIDTH-1:0] q,
  output logic                      pulse
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RESET_VALUE;
      pulse <= 1'b0;
    end else begin
      pulse <= we;
      if (we) begin
        for (int unsigned b = 0; b < AXI_STRB_WIDTH; b++) begin
          if (strb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers, with one-entry
// AW/W holding registers, a single outstanding B and a one-cycle read path.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned                ADDR_WIDTH  = 6,
  parameter int unsigned                NUM_REGS    = 8,
  parameter logic [AXI_DATA_WIDTH-1:0]  RESET_VALUE = 32'h0000_0000
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [2:0]                   s_axi_awprot,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0]    s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [2:0]                   s_axi_arprot,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [NUM_REGS*32-1:0]       reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  logic                      aw_full, w_full;
  logic [IDX_W-1:0]          aw_idx_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [AXI_STRB_WIDTH-1:0] w_strb_q;

  logic                      aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [IDX_W-1:0]          wr_idx, rd_idx;
  logic [AXI_DATA_WIDTH-1:0] wr_data, rd_data;
  logic [AXI_STRB_WIDTH-1:0] wr_strb;
  logic [NUM_REGS-1:0]       we;

  assign s_axi_awready = !areset && !aw_full;
  assign s_axi_wready  = !areset && !w_full;
  assign s_axi_arready = !areset && !s_axi_rvalid;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Commit may take AW/W straight from the bus so a same-cycle pair
  // produces B on the very next cycle instead of going through the holders.
  always_comb begin
    wr_idx  = aw_full ? aw_idx_q : s_axi_awaddr[ADDR_WIDTH-1:2];
    wr_data = w_full  ? w_data_q : s_axi_wdata;
    wr_strb = w_full  ? w_strb_q : s_axi_wstrb;
    commit  = (aw_full || aw_hs) && (w_full || w_hs) && !s_axi_bvalid;
    wr_ok   = in_range(32'(wr_idx), NUM_REGS);
    rd_idx  = s_axi_araddr[ADDR_WIDTH-1:2];
    rd_ok   = in_range(32'(rd_idx), NUM_REGS);
  end

  always_comb begin
    we      = '0;
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      we[i] = commit && wr_ok && (wr_idx == IDX_W'(i));
      if (rd_idx == IDX_W'(i)) rd_data = reg_q[32*i +: 32];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (commit) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_full  <= 1'b1;
        aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
    end
  end

  // Reads sample reg_q before this edge's commit lands: same-edge reads see old data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_ok ? rd_data : '0;
      s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    axi_lite_reg_cell #(.RESET_VALUE(RESET_VALUE)) u_cell (
      .clk   (aclk),
      .rst   (areset),
      .we    (we[i]),
      .strb  (wr_strb),
      .wdata (wr_data),
      .q     (reg_q[32*i +: 32]),
      .pulse (wr_pulse[i])
    );
  end

  logic unused;
  assign unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed and randomized checks of axi_lite_reg_slave against an
// array-based register model.
module tb_axi_lite_reg_slave;

  localparam logic [31:0] RV = 32'hCAFE_0001;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [5:0]   awaddr = '0, araddr = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [255:0] reg_q;
  logic [7:0]   wr_pulse;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [8];

  always #5 aclk = ~aclk;

  axi_lite_reg_slave #(.ADDR_WIDTH(6), .NUM_REGS(8), .RESET_VALUE(RV)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    model[idx] = (model[idx] & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    return (idx < 8) ? model[idx] : 32'h0;
  endfunction

  task automatic cyc();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic write_txn(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[5:2]);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b0;
    chk("wr_awready", awready, 1'b1);
    chk("wr_wready", wready, 1'b1);
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", bvalid, 1'b1);
    chk("wr_bresp", bresp, (idx < 8) ? 2'b00 : 2'b10);
    if (idx < 8) model_write(idx, d, s);
    chk("wr_reg_q", reg_q, model_vec());
    chk("wr_pulse", wr_pulse, (idx < 8) ? 8'(1 << idx) : 8'h00);
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    chk("wr_bvalid_clr", bvalid, 1'b0);
    chk("wr_pulse_clr", wr_pulse, 8'h00);
  endtask

  task automatic read_txn(input logic [5:0] a);
    int idx;
    idx = int'(a[5:2]);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    chk("rd_arready", arready, 1'b1);
    cyc();
    arvalid = 1'b0;
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_rdata", rdata, model_read(idx));
    chk("rd_rresp", rresp, (idx < 8) ? 2'b00 : 2'b10);
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk("rd_rvalid_clr", rvalid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = RV;

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_reg_q", reg_q, model_vec());
    chk("rst_pulse", wr_pulse, 8'h00);
    areset = 1'b0;
    #1;
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);
    @(negedge aclk);

    // Same-cycle AW/W, then read back
    write_txn(6'h04, 32'hDEADBEEF, 4'hF);
    chk("t1_reg1", reg_q[63:32], 32'hDEADBEEF);
    read_txn(6'h04);

    // W three cycles ahead of AW with partial strobes
    write_txn(6'h08, 32'hAABBCCDD, 4'hF);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    cyc();
    wvalid = 1'b0;
    chk("t2_w_held", wready, 1'b0);
    repeat (2) begin
      cyc();
      chk("t2_no_b", bvalid, 1'b0);
    end
    awaddr = 6'h08; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    chk("t2_bvalid", bvalid, 1'b1);
    chk("t2_bresp", bresp, 2'b00);
    model_write(2, 32'h11223344, 4'b0101);
    chk("t2_reg2", reg_q[95:64], 32'hAA22CC44);
    chk("t2_model", reg_q, model_vec());
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    repeat (2) begin
      chk("t2_single_b", bvalid, 1'b0);
      cyc();
    end

    // Out of range
    write_txn(6'h20, 32'h12345678, 4'hF);
    read_txn(6'h3C);

    // B backpressure with a second pair captured meanwhile
    awaddr = 6'h0C; awvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    cyc();
    chk("t4_bvalid", bvalid, 1'b1);
    model_write(3, 32'h0BAD_F00D, 4'hF);
    awaddr = 6'h10; wdata = 32'h7777_8888;
    chk("t4_aw2_ready", {awready, wready}, 2'b11);
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t4_captured", {awready, wready}, 2'b00);
    repeat (4) begin
      chk("t4_b_stable", {bvalid, bresp}, 3'b100);
      chk("t4_no_commit", reg_q, model_vec());
      cyc();
    end
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    chk("t4_b_done", bvalid, 1'b0);
    cyc();
    chk("t4_b2_valid", bvalid, 1'b1);
    model_write(4, 32'h7777_8888, 4'hF);
    chk("t4_b2_reg", reg_q, model_vec());
    chk("t4_b2_pulse", wr_pulse, 8'h10);
    bready = 1'b1;
    cyc();
    bready = 1'b0;

    // R backpressure, then same-edge read/write collision
    write_txn(6'h00, 32'h5A5A5A5A, 4'hF);
    araddr = 6'h00; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    repeat (4) begin
      chk("t5_r_stable", {rvalid, arready, rdata}, {1'b1, 1'b0, 32'h5A5A5A5A});
      cyc();
    end
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    araddr = 6'h00; arvalid = 1'b1;
    awaddr = 6'h00; awvalid = 1'b1; wdata = 32'hC3C3C3C3; wstrb = 4'hF; wvalid = 1'b1;
    cyc();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("t5_old_rdata", rdata, model[0]);
    model_write(0, 32'hC3C3C3C3, 4'hF);
    chk("t5_new_reg", reg_q, model_vec());
    chk("t5_both_valid", {rvalid, bvalid}, 2'b11);
    bready = 1'b1; rready = 1'b1;
    cyc();
    bready = 1'b0; rready = 1'b0;
    read_txn(6'h00);

    // Reset with a held AW and a pending R
    awaddr = 6'h04; awvalid = 1'b1; araddr = 6'h08; arvalid = 1'b1;
    cyc();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("t6_aw_held", awready, 1'b0);
    chk("t6_rvalid", rvalid, 1'b1);
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = RV;
    chk("t6_valids", {bvalid, rvalid}, 2'b00);
    chk("t6_regs", reg_q, model_vec());
    chk("t6_pulse", wr_pulse, 8'h00);
    #1;
    chk("t6_readies", {awready, wready, arready}, 3'b111);
    repeat (3) begin
      cyc();
      chk("t6_no_b", bvalid, 1'b0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) write_txn(a, $urandom, 4'($urandom_range(0, 15)));
      else read_txn(a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
Generic AXI4-Lite slave (responder) exposing a bank of NUM_REGS 32-bit read/write control registers. It is the target-side counterpart of the simple AXI4-Lite masters used in our example systems. It accepts AW and W channels independently, applies byte strobes, and handles B/R backpressure. Out-of-range accesses return SLVERR. It sits between any AXI4-Lite master and user logic that consumes the register outputs.

Parameters:
ADDR_WIDTH, 6, byte-address width of awaddr/araddr.
NUM_REGS, 8, number of 32-bit registers; must satisfy 1 <= NUM_REGS <= 2^(ADDR_WIDTH-2).
RESET_VALUE, 32'h0000_0000, reset value loaded into every register.

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
reg_q  out  NUM_REGS*32  register contents; reg i at bits [32*i+31:32*i]
wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after reg i is written

Behaviour:
- Clock and reset: single clock aclk. Reset is synchronous, active-high on areset.
- Reset values: every register = RESET_VALUE. awready = wready = arready = 0. bvalid = rvalid = 0. bresp = rresp = 0, rdata = 0, wr_pulse = 0. The ready outputs rise on the first cycle after areset deasserts.
- Reset mid-transaction: any held AW/W and any pending B/R are discarded, with no write performed.
- Register index: idx = addr[ADDR_WIDTH-1:2]. addr[1:0] is ignored. idx >= NUM_REGS is out of range.
- Write path:
  - One-entry holding register for AW (aw_full) and one for W (w_full).
  - awready = !aw_full; wready = !w_full. AW and W may arrive in any order or in the same cycle.
  - Commit fires when aw_full && w_full && !bvalid. On that edge:
    - If in range: each byte b with wstrb[b]=1 updates reg[idx][8b+7:8b]; bresp = 2'b00. wr_pulse[idx] = 1 for exactly that cycle, even if wstrb = 0.
    - If out of range: no register change, no pulse, bresp = 2'b10.
    - In both cases: bvalid = 1, and aw_full and w_full clear.
  - bvalid holds with a stable bresp until bready; it clears on the bvalid && bready edge.
  - New AW/W may be captured while bvalid = 1, but no commit happens until B completes. At most one outstanding write response.
  - Minimum write latency: AW and W accepted in cycle N, bvalid asserted in cycle N+1.
- Read path:
  - arready = !rvalid.
  - On arvalid && arready: rdata = reg[idx] (or 0 if out of range), rresp = 2'b00 (or 2'b10), rvalid = 1 on the next edge. Latency is one cycle.
  - rdata and rresp stay stable while rvalid && !rready. rvalid clears on rvalid && rready.
  - No AR can be accepted in the same cycle R completes; the throughput limit is one read per 2 cycles.
- Read/write collision:
  - A read accepted on the same edge as a commit to the same register returns the pre-write value.
  - A later read sees the new value.
- Read and write channels operate fully concurrently; there is no arbitration between them.
- RTL budget: roughly 150–250 lines.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - AXI_DATA_WIDTH = 32, AXI_STRB_WIDTH = 4.
- Sub-module axi_lite_reg_cell: one 32-bit register with byte-enable write, a synchronous reset to RESET_VALUE, and write-pulse generation. It is instantiated NUM_REGS times via generate.
- The top level holds the AW/W holding registers, the commit logic, B/R handshake logic and the read mux.

Test Plan:
- Reset, then AW(0x04) and W(0xDEADBEEF, strb 4'hF) in the same cycle → bvalid next cycle with bresp 00, reg_q[63:32] = 0xDEADBEEF, wr_pulse = 8'b0000_0010 for one cycle. Then AR(0x04) → rvalid one cycle later with rdata 0xDEADBEEF, rresp 00.
- W(0x11223344, strb 4'b0101) presented 3 cycles before AW(0x08), with reg 2 = 0xAABBCCDD → W held (wready = 0 after capture), then reg 2 = 0xAA22CC44 and a single B response.
- AW(0x20) out of range with NUM_REGS = 8 → bresp 10, no reg_q change, wr_pulse = 0. AR(0x3C) → rresp 10, rdata 0.
- bready held low 5 cycles after a write, with a second AW/W pair issued meanwhile → bvalid and bresp stable, second pair captured but not committed. After the B handshake, the second commit's bvalid asserts the next cycle.
- rready low 4 cycles with reg 0 = 0x5A5A5A5A → rvalid and rdata stable and arready = 0 throughout. Same-edge read and write of reg 0 → R returns the old value 0x5A5A5A5A.
- areset asserted while aw_full = 1 and rvalid = 1 → next cycle all valids 0, registers = RESET_VALUE, and no B response is ever issued for the dropped write.
